// File: rtl/brg_xcel_link_concentrator.sv
// Credit-gated round-robin concentrator: N request channels merged onto one output link.
// Define BRG_XCEL_CONCENTRATOR_OUT_REG_EN for a 2-entry registered output buffer; default is combinational.
module brg_xcel_link_concentrator #(
  parameter int num_in_p          = 4,
  parameter int width_p           = 64,
  parameter int max_out_credits_p = 16,
  localparam int id_width_lp      = $clog2(num_in_p),
  localparam int cred_width_lp    = $clog2(max_out_credits_p + 1)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_in_p-1:0]                in_v_i,
  input  logic [num_in_p*width_p-1:0]        in_data_i,
  output logic [num_in_p-1:0]                in_ready_o,
  output logic                               out_v_o,
  output logic [width_p-1:0]                 out_data_o,
  output logic [id_width_lp-1:0]             out_id_o,
  input  logic                               out_ready_i,
  input  logic                               credit_v_i,
  input  logic [id_width_lp-1:0]             credit_id_i,
  output logic [num_in_p*cred_width_lp-1:0]  credits_o,
  output logic                               idle_o,
  output logic                               err_o
);

  localparam logic [cred_width_lp-1:0] max_cred_lp = cred_width_lp'(max_out_credits_p);

  logic [cred_width_lp-1:0] credits_q [num_in_p];
  logic [cred_width_lp-1:0] credits_d [num_in_p];
  logic                     err_q, err_d;
  logic [id_width_lp-1:0]   last_q, last_d;

  logic [num_in_p-1:0]      elig;
  logic [num_in_p-1:0]      dec_v;
  logic [num_in_p-1:0]      inc_v;
  logic [num_in_p-1:0]      full_v;
  logic                     sel_v;
  logic [id_width_lp-1:0]   sel_id;
  logic                     grant_v;
  logic [id_width_lp-1:0]   grant_id;
  logic                     buf_empty;
  logic [31:0]              credit_id_ext;
  logic                     credit_id_legal;

  assign credit_id_ext   = 32'(credit_id_i);
  assign credit_id_legal = credit_id_ext < 32'(num_in_p);

  genvar gi;
  generate
    for (gi = 0; gi < num_in_p; gi++) begin : g_chan
      assign elig[gi]       = in_v_i[gi] & (credits_q[gi] != '0);
      assign dec_v[gi]      = grant_v & (grant_id == id_width_lp'(gi));
      assign inc_v[gi]      = credit_v_i & credit_id_legal & (credit_id_i == id_width_lp'(gi));
      assign full_v[gi]     = (credits_q[gi] == max_cred_lp);
      assign in_ready_o[gi] = dec_v[gi];
      assign credits_o[gi*cred_width_lp +: cred_width_lp] = credits_q[gi];
    end
  endgenerate

  // Search upward starting just past the last granted channel, wrapping at num_in_p.
  always_comb begin
    sel_v  = 1'b0;
    sel_id = '0;
    for (int k = 1; k <= num_in_p; k++) begin
      if (!sel_v && elig[(int'(last_q) + k) % num_in_p]) begin
        sel_v  = 1'b1;
        sel_id = id_width_lp'((int'(last_q) + k) % num_in_p);
      end
    end
  end

  always_comb begin
    err_d  = err_q;
    last_d = grant_v ? grant_id : last_q;
    if (credit_v_i && !credit_id_legal) begin
      err_d = 1'b1;
    end
    for (int i = 0; i < num_in_p; i++) begin
      credits_d[i] = credits_q[i];
      // A same-cycle grant and return cancel out; a return into a full counter is an overflow.
      if (inc_v[i] && !dec_v[i]) begin
        if (full_v[i]) begin
          err_d = 1'b1;
        end else begin
          credits_d[i] = credits_q[i] + cred_width_lp'(1);
        end
      end else if (dec_v[i] && !inc_v[i]) begin
        credits_d[i] = credits_q[i] - cred_width_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_in_p; i++) begin
        credits_q[i] <= max_cred_lp;
      end
      err_q  <= 1'b0;
      last_q <= id_width_lp'(num_in_p - 1);
    end else begin
      for (int i = 0; i < num_in_p; i++) begin
        credits_q[i] <= credits_d[i];
      end
      err_q  <= err_d;
      last_q <= last_d;
    end
  end

`ifdef BRG_XCEL_CONCENTRATOR_OUT_REG_EN
  logic [width_p-1:0]     buf_data_q [2];
  logic [width_p-1:0]     buf_data_d [2];
  logic [id_width_lp-1:0] buf_id_q [2];
  logic [id_width_lp-1:0] buf_id_d [2];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic                   pop;

  // Accepting only on free space keeps in_ready_o independent of out_ready_i.
  always_comb begin
    grant_v    = sel_v && (count_q != 2'd2) && !reset_i;
    grant_id   = sel_id;
    out_v_o    = (count_q != 2'd0) && !reset_i;
    out_data_o = buf_data_q[rd_ptr_q];
    out_id_o   = buf_id_q[rd_ptr_q];
    pop        = out_v_o && out_ready_i;
    buf_empty  = (count_q == 2'd0);
    buf_data_d = buf_data_q;
    buf_id_d   = buf_id_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (grant_v) begin
      buf_data_d[wr_ptr_q] = in_data_i[int'(grant_id)*width_p +: width_p];
      buf_id_d[wr_ptr_q]   = grant_id;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, grant_v} - {1'b0, pop};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    buf_data_q <= buf_data_d;
    buf_id_q   <= buf_id_d;
  end
`else
  logic                   lock_v_q, lock_v_d;
  logic [id_width_lp-1:0] lock_id_q, lock_id_d;
  logic                   pick_v;
  logic [id_width_lp-1:0] pick_id;

  // While stalled, hold the offered channel so a late credit return cannot re-steer the output.
  always_comb begin
    if (lock_v_q && elig[lock_id_q]) begin
      pick_v  = 1'b1;
      pick_id = lock_id_q;
    end else begin
      pick_v  = sel_v;
      pick_id = sel_id;
    end
    out_v_o    = pick_v && !reset_i;
    out_id_o   = pick_id;
    out_data_o = in_data_i[int'(pick_id)*width_p +: width_p];
    grant_v    = out_v_o && out_ready_i;
    grant_id   = pick_id;
    lock_v_d   = out_v_o && !out_ready_i;
    lock_id_d  = pick_id;
    buf_empty  = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_v_q  <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_v_q  <= lock_v_d;
      lock_id_q <= lock_id_d;
    end
  end
`endif

  assign idle_o = reset_i | ((&full_v) & buf_empty);
  assign err_o  = err_q;

endmodule
